// File: rtl/layer_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : layer_gen                                                       |
// | Purpose  : LFSR-driven block-layer generator with an initial stack fill    |
// |            and a tick-counted delay between a request and each new layer.  |
// | Option   : define LAYER_GEN_HAZARD_EN to mark some non-path blocks as      |
// |            hazards (block_type_out=0 while layer_map_out=1).               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module layer_gen #(
  parameter int          DELAY_MS    = 200,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          FILL_LAYERS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       module_en,
  input  logic       one_ms_tick,
  input  logic       next_req,
  output logic       load_layer,
  output logic [0:6] layer_map_out,
  output logic [0:6] block_type_out,
  output logic       busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FILL_GEN  = 3'd1;
  localparam logic [2:0] S_FILL_LOAD = 3'd2;
  localparam logic [2:0] S_READY     = 3'd3;
  localparam logic [2:0] S_WAIT      = 3'd4;
  localparam logic [2:0] S_GEN       = 3'd5;
  localparam logic [2:0] S_LOAD      = 3'd6;

  localparam int              FILL_W     = $clog2(FILL_LAYERS + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_LAYERS - 1);
  localparam logic [9:0]      DELAY_LAST = 10'(DELAY_MS - 1);
  localparam logic [2:0]      P_CENTER   = 3'd3;

  logic [2:0]        state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [2:0]        p_q, p_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [9:0]        tick_cnt_q, tick_cnt_d;
  logic              load_q, load_d;
  logic [0:6]        map_q, map_d;
  logic [0:6]        type_q, type_d;
  logic              busy_q, busy_d;

  logic [2:0]        w_p_next;
  logic [0:6]        w_map_new;
  logic [0:6]        w_type_new;
  logic              w_map_bit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      p_q        <= P_CENTER;
      fill_cnt_q <= '0;
      tick_cnt_q <= '0;
      load_q     <= 1'b0;
      map_q      <= '0;
      type_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      p_q        <= p_d;
      fill_cnt_q <= fill_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      load_q     <= load_d;
      map_q      <= map_d;
      type_q     <= type_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!module_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_FILL_GEN;
        S_FILL_GEN:  state_d = S_FILL_LOAD;
        S_FILL_LOAD: state_d = (fill_cnt_q == FILL_LAST) ? S_READY : S_FILL_GEN;
        S_READY:     if (next_req) state_d = S_WAIT;
        S_WAIT:      if (one_ms_tick && (tick_cnt_q == DELAY_LAST)) state_d = S_GEN;
        S_GEN:       state_d = S_LOAD;
        S_LOAD:      state_d = S_READY;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // New-layer composition from the pre-advance LFSR value
  always_comb begin
    if (p_q == 3'd0) begin
      w_p_next = 3'd1;
    end else if (p_q >= 3'd6) begin
      w_p_next = 3'd5;
    end else begin
      w_p_next = lfsr_q[0] ? (p_q + 3'd1) : (p_q - 3'd1);
    end
    w_map_new  = '0;
    w_type_new = '0;
    w_map_bit  = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (3'(k) == w_p_next) begin
        w_map_new[k]  = 1'b1;
        w_type_new[k] = 1'b1;
      end else begin
        w_map_bit    = lfsr_q[k+1] & lfsr_q[k+8];
        w_map_new[k] = w_map_bit;
`ifdef LAYER_GEN_HAZARD_EN
        w_type_new[k] = w_map_bit & ~lfsr_q[k];
`else
        w_type_new[k] = w_map_bit;
`endif
      end
    end
  end

  // Output and datapath logic
  always_comb begin
    lfsr_d     = lfsr_q;
    p_d        = p_q;
    fill_cnt_d = fill_cnt_q;
    tick_cnt_d = tick_cnt_q;
    map_d      = map_q;
    type_d     = type_q;
    load_d     = (state_d == S_FILL_LOAD) || (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE) && (state_d != S_READY);
    if (!module_en) begin
      // Abort clears the visible layer and recentres the path; LFSR is kept
      map_d  = '0;
      type_d = '0;
      p_d    = P_CENTER;
    end else begin
      case (state_q)
        S_IDLE:      fill_cnt_d = '0;
        S_FILL_GEN, S_GEN: begin
          lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
          p_d    = w_p_next;
          map_d  = w_map_new;
          type_d = w_type_new;
        end
        S_FILL_LOAD: fill_cnt_d = fill_cnt_q + 1'b1;
        S_READY:     if (next_req) tick_cnt_d = '0;
        S_WAIT: begin
          if (one_ms_tick && (tick_cnt_q != 10'h3FF)) tick_cnt_d = tick_cnt_q + 10'd1;
        end
        default: ;
      endcase
    end
  end

  assign load_layer     = load_q;
  assign layer_map_out  = map_q;
  assign block_type_out = type_q;
  assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_layer_gen                                                    |
// | Purpose  : Self-checking bench for layer_gen against a behavioural model.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_layer_gen;

  localparam int          TB_DELAY = 3;
  localparam logic [15:0] TB_SEED  = 16'hACE1;
  localparam int          TB_FILL  = 5;

  localparam logic [2:0] M_OFF   = 3'd0;
  localparam logic [2:0] M_FILL  = 3'd1;
  localparam logic [2:0] M_READY = 3'd2;
  localparam logic [2:0] M_WAIT  = 3'd3;
  localparam logic [2:0] M_GEN   = 3'd4;
  localparam logic [2:0] M_LOAD  = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       module_en;
  logic       one_ms_tick;
  logic       next_req;
  logic       load_layer;
  logic [0:6] layer_map_out;
  logic [0:6] block_type_out;
  logic       busy;

  layer_gen #(
    .DELAY_MS   (TB_DELAY),
    .LFSR_SEED  (TB_SEED),
    .FILL_LAYERS(TB_FILL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .module_en     (module_en),
    .one_ms_tick   (one_ms_tick),
    .next_req      (next_req),
    .load_layer    (load_layer),
    .layer_map_out (layer_map_out),
    .block_type_out(block_type_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Expected registered outputs for the current cycle plus the abstract model state
  typedef struct packed {
    logic [2:0]  mode;
    logic [10:0] cnt;
    logic [15:0] lfsr;
    logic [2:0]  p;
    logic        load;
    logic [0:6]  map;
    logic [0:6]  typ;
    logic        busy;
  } mstate_t;

  mstate_t    m;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic       chk_en = 1'b0;
  int         load_q[$];
  logic [0:6] map_q[$];
  logic [0:6] typ_q[$];

  function automatic mstate_t gen_layer(input mstate_t s);
    mstate_t     n;
    logic [15:0] l;
    int          np;
    logic        bit_m;
    n = s;
    l = s.lfsr;
    if (s.p == 3'd0)      np = 1;
    else if (s.p == 3'd6) np = 5;
    else                  np = l[0] ? int'(s.p) + 1 : int'(s.p) - 1;
    for (int k = 0; k < 7; k++) begin
      if (k == np) begin
        n.map[k] = 1'b1;
        n.typ[k] = 1'b1;
      end else begin
        bit_m    = l[k+1] & l[k+8];
        n.map[k] = bit_m;
`ifdef LAYER_GEN_HAZARD_EN
        n.typ[k] = bit_m & ~l[k];
`else
        n.typ[k] = bit_m;
`endif
      end
    end
    n.p    = 3'(np);
    n.lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    n.load = 1'b1;
    return n;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic r, input logic en,
                                   input logic tk, input logic rq);
    mstate_t n;
    n = s;
    n.load = 1'b0;
    if (r) begin
      n      = '0;
      n.lfsr = TB_SEED;
      n.p    = 3'd3;
      n.mode = M_OFF;
    end else if (!en) begin
      n.mode = M_OFF;
      n.cnt  = '0;
      n.map  = '0;
      n.typ  = '0;
      n.p    = 3'd3;
      n.busy = 1'b0;
    end else begin
      case (s.mode)
        M_OFF: begin
          n.mode = M_FILL;
          n.cnt  = '0;
          n.busy = 1'b1;
        end
        M_FILL: begin
          // cnt = cycles since the fill began; even = generate, odd = load shown
          if (s.cnt[0] == 1'b0) begin
            n     = gen_layer(s);
            n.cnt = s.cnt + 11'd1;
          end else if (int'(s.cnt) == 2 * TB_FILL - 1) begin
            n.mode = M_READY;
            n.busy = 1'b0;
          end else begin
            n.cnt = s.cnt + 11'd1;
          end
        end
        M_READY: begin
          if (rq) begin
            n.mode = M_WAIT;
            n.cnt  = '0;
            n.busy = 1'b1;
          end
        end
        M_WAIT: begin
          if (tk) begin
            if (int'(s.cnt) + 1 == TB_DELAY) n.mode = M_GEN;
            else if (s.cnt < 11'd1023)       n.cnt  = s.cnt + 11'd1;
          end
        end
        M_GEN: begin
          n      = gen_layer(s);
          n.mode = M_LOAD;
        end
        default: begin
          n.mode = M_READY;
          n.busy = 1'b0;
        end
      endcase
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    m   <= step(m, rst, module_en, one_ms_tick, next_req);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("load", 16'(load_layer), 16'(m.load));
      check("busy", 16'(busy), 16'(m.busy));
      check("map", 16'(layer_map_out), 16'(m.map));
      check("type", 16'(block_type_out), 16'(m.typ));
      if (load_layer) begin
        load_q.push_back(cyc);
        map_q.push_back(layer_map_out);
        typ_q.push_back(block_type_out);
        check("type_implies_map", 16'(block_type_out & ~layer_map_out), 16'd0);
        check("path_solid", {14'd0, layer_map_out[m.p], block_type_out[m.p]}, 16'd3);
`ifndef LAYER_GEN_HAZARD_EN
        check("type_eq_map", 16'(block_type_out), 16'(layer_map_out));
`endif
      end
    end
  end

  task automatic cycle(input logic t, input logic q);
    one_ms_tick = t;
    next_req    = q;
    @(posedge clk);
    #1;
    one_ms_tick = 1'b0;
    next_req    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int base;
    int t3;
    rst         = 1'b1;
    module_en   = 1'b0;
    one_ms_tick = 1'b0;
    next_req    = 1'b0;
    t3          = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst    = 1'b0;

    // Reset with enable low: silent for 100 cycles
    repeat (100) cycle(1'b0, 1'b0);
    check("idle_loads", 16'(load_q.size()), 16'd0);
    check("idle_busy", 16'(busy), 16'd0);
    check("idle_map", 16'(layer_map_out), 16'd0);

    // Initial fill
    module_en = 1'b1;
    n0 = cyc;
    repeat (14) cycle(1'b0, 1'b0);
    check("fill_count", 16'(load_q.size()), 16'd5);
    for (int i = 0; i < 5 && i < load_q.size(); i++)
      check("fill_cycle", 16'(load_q[i] - n0), 16'(2 + 2 * i));
    if (map_q.size() >= 2) begin
      check("fill_l1_map", 16'(map_q[0]), 16'(7'b0000110));
      check("fill_l2_map", 16'(map_q[1]), 16'(7'b1000011));
`ifdef LAYER_GEN_HAZARD_EN
      check("fill_l1_type", 16'(typ_q[0]), 16'(7'b0000100));
      check("fill_l2_type", 16'(typ_q[1]), 16'(7'b0000010));
`else
      check("fill_l1_type", 16'(typ_q[0]), 16'(7'b0000110));
      check("fill_l2_type", 16'(typ_q[1]), 16'(7'b1000011));
`endif
    end
    check("fill_done_busy", 16'(busy), 16'd0);

    // Delay: ticks every 10 cycles, extra requests during WAIT
    base = load_q.size();
    cycle(1'b0, 1'b1);
    for (int j = 0; j < 30; j++) begin
      if (j % 10 == 4) t3 = cyc;
      cycle(j % 10 == 4, (j == 7) || (j == 19));
    end
    repeat (5) cycle(1'b0, 1'b0);
    check("delay_count", 16'(load_q.size() - base), 16'd1);
    if (load_q.size() > base) check("delay_latency", 16'(load_q[base] - t3), 16'd2);

    // Long run of generated layers, including ticks that coincide with the request
    base = load_q.size();
    for (int i = 0; i < 200; i++) begin
      cycle(1'(i % 2), 1'b1);
      repeat (3) cycle(1'b1, 1'b0);
      repeat (3) cycle(1'b0, 1'b0);
    end
    check("clamp_count", 16'(load_q.size() - base), 16'd200);

    // Abort mid-WAIT, then refill
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    module_en = 1'b0;
    cycle(1'b0, 1'b0);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_map", 16'(layer_map_out), 16'd0);
    check("abort_load", 16'(load_layer), 16'd0);
    repeat (3) cycle(1'b0, 1'b0);
    module_en = 1'b1;
    n0 = cyc;
    base = load_q.size();
    repeat (14) cycle(1'b0, 1'b0);
    check("refill_count", 16'(load_q.size() - base), 16'd5);
    if (load_q.size() > base) check("refill_first", 16'(load_q[base] - n0), 16'd2);

    // Reset overrides enable and restores the seed
    rst = 1'b1;
    cycle(1'b1, 1'b1);
    rst = 1'b0;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_map", 16'(layer_map_out), 16'd0);
    check("rst_load", 16'(load_layer), 16'd0);
    base = load_q.size();
    repeat (14) cycle(1'b0, 1'b0);
    check("rst_fill_count", 16'(load_q.size() - base), 16'd5);
    if (map_q.size() > base) check("rst_seed_map", 16'(map_q[base]), 16'(7'b0000110));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer_gen.md
LAYER_GEN -- requirements
Module: layer_gen

Interface
REQ-001 Parameter: DELAY_MS, default 200, number of one_ms_tick pulses from next_req to the new layer load (range 1..1023).
REQ-002 Parameter: LFSR_SEED, default 16'hACE1, LFSR value after reset; must be nonzero.
REQ-003 Parameter: FILL_LAYERS, default 5, number of layers emitted on enable to pre-fill the block stack.
REQ-004 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: module_en  input  1  block enable; low forces IDLE.
REQ-007 Port: one_ms_tick  input  1  single-cycle 1 ms strobe.
REQ-008 Port: next_req  input  1  single-cycle request for one new layer; driven by the OR of the jump_left and jump_right strobes.
REQ-009 Port: load_layer  output  1  single-cycle strobe; layer outputs valid in the same cycle.
REQ-010 Port: layer_map_out  output  [0:6]  block present per column (index 0 = leftmost).
REQ-011 Port: block_type_out  output  [0:6]  1 = solid block, 0 = hazard or empty.
REQ-012 Port: busy  output  1  high in any state other than IDLE and READY.

Function
REQ-013 The FSM states are IDLE, FILL_GEN, FILL_LOAD, READY, WAIT, GEN and LOAD; all outputs are registered.
REQ-014 IDLE -> FILL_GEN on the first cycle with module_en=1; the fill counter is cleared.
REQ-015 FILL_GEN -> FILL_LOAD always. FILL_LOAD pulses load_layer and increments the fill counter. It returns to FILL_GEN until FILL_LAYERS loads are done, then goes to READY.
REQ-016 Fill timing: load pulses occur on alternate cycles; the first pulse comes 2 cycles after module_en rises.
REQ-017 READY -> WAIT on next_req=1; the tick counter is cleared.
REQ-018 WAIT counts one_ms_tick pulses; on the DELAY_MS-th tick it goes to GEN. A tick in the same cycle as the WAIT entry is not counted.
REQ-019 GEN -> LOAD; LOAD pulses load_layer for exactly 1 cycle and then goes to READY.
REQ-020 next_req in any state other than READY is ignored; it is neither queued nor counted.
REQ-021 LFSR: 16 bits, shifts left, new bit0 = l[15]^l[13]^l[12]^l[10]; it advances exactly once per GEN or FILL_GEN cycle and holds otherwise.
REQ-022 Path column p (0..6): in each GEN or FILL_GEN cycle, p_next = p+1 if l[0]=1 else p-1, evaluated using the pre-advance LFSR value l. Clamps: p=0 forces +1, p=6 forces -1.
REQ-023 New-layer composition, using l = pre-advance LFSR:
  - the path column p_next gets map=1 and type=1;
  - each other column k gets map[k] = l[k+1] & l[k+8].
REQ-024 layer_map_out and block_type_out update in the GEN or FILL_GEN cycle. They hold their value until the next generation.
REQ-025 Every emitted layer has at least one solid block, and its path column differs from the previous layer's path column by exactly 1.
REQ-026 For every column k, block_type_out[k]=1 only if layer_map_out[k]=1.
REQ-027 When module_en=0 in any state, the block goes to IDLE on the next cycle. In that cycle load_layer, layer_map_out and block_type_out go to 0 and p goes to 3; the LFSR retains its value. This holds even mid-WAIT or mid-FILL.
REQ-028 The tick counter is 10 bits wide and saturates; it never wraps.

Reset
REQ-029 When rst=1, the following are forced on the next clock edge, and rst has priority over module_en:
  - FSM = IDLE;
  - LFSR = LFSR_SEED;
  - p = 3;
  - fill and tick counters = 0;
  - load_layer = 0, layer_map_out = 7'b0, block_type_out = 7'b0, busy = 0.

Configuration
REQ-030 Macro LAYER_GEN_HAZARD_EN.
  - Defined: for each non-path column k, block_type_out[k] = map[k] & ~l[k]; path columns are always type 1.
  - Undefined: block_type_out = layer_map_out for every layer, so no hazards are generated.

Verification
REQ-031 Reset scenario: rst held for 3 cycles, then released with module_en=0 -> outputs all 0, busy=0, no load_layer pulse for 100 cycles.
REQ-032 Fill scenario: module_en rises at cycle N -> 5 load_layer pulses at N+2, N+4, N+6, N+8 and N+10; after the last, busy=0. Path columns follow REQ-022 starting from p=3, with LFSR_SEED=16'hACE1 checked against a reference model.
REQ-033 Delay scenario: DELAY_MS=3, next_req in READY, ticks every 10 cycles -> exactly 1 load_layer pulse, 2 cycles after the 3rd tick; extra next_req pulses during WAIT produce no extra load.
REQ-034 Clamp scenario: 200 generated layers -> the path column always stays in 0..6, |Δp|=1 every layer, and map[p]=type[p]=1; run with the macro on and off. With the macro off, type==map every layer.
REQ-035 Abort scenario: module_en dropped mid-WAIT, then raised again -> IDLE next cycle with outputs 0; the next fill restarts with 5 loads, p restarts at 3, and the LFSR continues from its retained value (not the seed).
